// File: rtl/alu_seq_slice_adder.sv
// Multi-cycle add/subtract ALU: adds one SLICE-bit digit per clock, LSB slice first,
// with a registered ripple carry; result and flags are published together at completion.
module alu_seq_slice_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Z,
  output logic             sign,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             parity
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, acc_reg;
  logic             cin_reg;
  logic [CW-1:0]    cnt_reg;

  logic [SLICE-1:0] a_slice, b_slice;
  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] zn;
  logic             last_slice, accept;

  assign a_slice    = a_reg[int'(cnt_reg)*SLICE +: SLICE];
  assign b_slice    = b_reg[int'(cnt_reg)*SLICE +: SLICE];
  assign slice_sum  = {1'b0, a_slice} + {1'b0, b_slice} + (SLICE+1)'(cin_reg);
  assign last_slice = (cnt_reg == CW'(NSLICE - 1));
  assign accept     = start && (state_reg != S_RUN);

  // Assembled result including the slice being added this cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NSLICE; gi++) begin : g_zn
      assign zn[gi*SLICE +: SLICE] = (cnt_reg == CW'(gi)) ? slice_sum[SLICE-1:0]
                                                           : acc_reg[gi*SLICE +: SLICE];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (last_slice) state_next = S_DONE;
      S_DONE:  state_next = start ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == S_RUN);
    done = (state_reg == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      acc_reg  <= '0;
      cin_reg  <= 1'b0;
      cnt_reg  <= '0;
      Z        <= '0;
      sign     <= 1'b0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      parity   <= 1'b0;
    end else if (accept) begin
      // Subtract is A + ~B + 1: invert B here and seed the carry with op.
      a_reg   <= X;
      b_reg   <= op ? ~Y : Y;
      cin_reg <= op;
      cnt_reg <= '0;
    end else if (state_reg == S_RUN) begin
      acc_reg <= zn;
      cin_reg <= slice_sum[SLICE];
      cnt_reg <= cnt_reg + CW'(1);
      if (last_slice) begin
        Z        <= zn;
        carry    <= slice_sum[SLICE];
        sign     <= zn[WIDTH-1];
        zero     <= ~|zn;
        parity   <= ~^zn;
        overflow <= (a_reg[WIDTH-1] & b_reg[WIDTH-1] & ~zn[WIDTH-1]) |
                    (~a_reg[WIDTH-1] & ~b_reg[WIDTH-1] & zn[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_slice_adder.sv
// Randomised self-checking bench for alu_seq_slice_adder (16/4 and 32/8 instances)
// against an arithmetic reference model.
module tb_alu_seq_slice_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        start16 = 1'b0, op16 = 1'b0;
  logic [15:0] x16 = '0, y16 = '0, z16;
  logic        busy16, done16, sign16, zero16, carry16, ovf16, par16;

  logic        start32 = 1'b0, op32 = 1'b0;
  logic [31:0] x32 = '0, y32 = '0, z32;
  logic        busy32, done32, sign32, zero32, carry32, ovf32, par32;

  alu_seq_slice_adder #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .X(x16), .Y(y16),
    .busy(busy16), .done(done16), .Z(z16), .sign(sign16), .zero(zero16),
    .carry(carry16), .overflow(ovf16), .parity(par16)
  );

  alu_seq_slice_adder #(.WIDTH(32), .SLICE(8)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .X(x32), .Y(y32),
    .busy(busy32), .done(done32), .Z(z32), .sign(sign32), .zero(zero32),
    .carry(carry32), .overflow(ovf32), .parity(par32)
  );

  bit          sel32 = 1'b0;
  logic        busy_o, done_o;
  logic [63:0] z_o;
  logic [4:0]  fl_o;
  longint unsigned prev16 = 0, prev32 = 0;

  always_comb begin
    if (sel32) begin
      busy_o = busy32;
      done_o = done32;
      z_o    = {32'd0, z32};
      fl_o   = {sign32, zero32, carry32, ovf32, par32};
    end else begin
      busy_o = busy16;
      done_o = done16;
      z_o    = {48'd0, z16};
      fl_o   = {sign16, zero16, carry16, ovf16, par16};
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Flags packed as {sign, zero, carry, overflow, parity}.
  function automatic void model(input int w, input longint unsigned x, input longint unsigned y,
                                input bit op, output longint unsigned z, output logic [4:0] fl);
    longint unsigned mask, zz;
    longint half, sx, sy, sr;
    bit c, v;
    mask = (64'd1 << w) - 64'd1;
    half = longint'(64'd1 << (w - 1));
    sx   = (longint'(x) >= half) ? longint'(x) - 2 * half : longint'(x);
    sy   = (longint'(y) >= half) ? longint'(y) - 2 * half : longint'(y);
    sr   = op ? sx - sy : sx + sy;
    zz   = (op ? x - y : x + y) & mask;
    c    = op ? (x >= y) : ((x + y) > mask);
    v    = (sr >= half) || (sr < -half);
    z    = zz;
    fl   = {zz[w-1], zz == 0, c, v, ($countones(zz) % 2) == 0};
  endfunction

  task automatic drive(input bit s, input longint unsigned x, input longint unsigned y, input bit o);
    if (sel32) begin
      start32 = s; x32 = x[31:0]; y32 = y[31:0]; op32 = o;
    end else begin
      start16 = s; x16 = x[15:0]; y16 = y[15:0]; op16 = o;
    end
  endtask

  // Call at a negedge with busy=0; returns at the negedge of the done cycle.
  // keep=1 leaves start high during RUN with other operands (must be ignored,
  // then accepted in DONE as the next operation).
  task automatic do_op(input string tag, input longint unsigned x, input longint unsigned y,
                       input bit op, input bit keep);
    longint unsigned ez, prev;
    logic [4:0] ef;
    int n;
    int w = sel32 ? 32 : 16;
    prev = sel32 ? prev32 : prev16;
    model(w, x, y, op, ez, ef);
    drive(1'b1, x, y, op);
    @(posedge clk);
    @(negedge clk);
    if (keep) drive(1'b1, 64'h1234, 64'h4321, 1'b0);
    else      drive(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    check({tag, "/busy"}, 64'(busy_o), 64'd1);
    check({tag, "/zhold"}, z_o, prev);
    n = 1;
    while (!done_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/latency"}, 64'(n), 64'd5);
    check({tag, "/z"}, z_o, ez);
    check({tag, "/flags"}, 64'(fl_o), 64'(ef));
    check({tag, "/idle"}, 64'(busy_o), 64'd0);
    $display("op %s: x=%0h y=%0h op=%0d z=%0h flags=%b", tag, x, y, op, z_o, fl_o);
    if (sel32) prev32 = ez; else prev16 = ez;
  endtask

  initial begin
    bit seen;
    int dones;
    longint unsigned rx, ry;

    @(negedge clk);
    @(negedge clk);
    check("reset16", {busy16, done16, sign16, zero16, carry16, ovf16, par16, z16}, 64'd0);
    check("reset32", {busy32, done32, sign32, zero32, carry32, ovf32, par32, z32}, 64'd0);
    rst = 1'b0;

    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy16 || done16 || busy32 || done32) seen = 1'b1;
    end
    check("idle10", 64'(seen), 64'd0);

    do_op("add_ovf", 64'h7FFF, 64'h0001, 1'b0, 1'b0);
    do_op("add_wrap", 64'hFFFF, 64'h0001, 1'b0, 1'b0);
    do_op("sub_neg", 64'h0005, 64'h0007, 1'b1, 1'b0);
    do_op("sub_ovf", 64'h8000, 64'h0001, 1'b1, 1'b0);
    do_op("ign_start", 64'h0F0F, 64'h1111, 1'b0, 1'b1);
    do_op("b2b", 64'h1234, 64'h4321, 1'b0, 1'b0);

    // Abort in the 3rd RUN cycle: outputs clear without any clock edge.
    drive(1'b1, 64'h00FF, 64'h0100, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 64'h0, 64'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort/z", z_o, 64'd0);
    check("abort/ctl", 64'({busy_o, done_o, fl_o}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_o) dones++;
    end
    check("abort/nodone", 64'(dones), 64'd0);
    $display("op abort: z=%0h busy=%0d done_count=%0d", z_o, busy_o, dones);
    prev16 = 0;
    prev32 = 0;

    for (int i = 0; i < 20; i++) begin
      rx = 64'($urandom_range(0, 65535));
      ry = 64'($urandom_range(0, 65535));
      if (i % 5 == 0) rx = 64'h8000;
      if (i % 7 == 0) ry = rx;
      do_op("rand16", rx, ry, 1'($urandom), 1'b0);
    end

    sel32 = 1'b1;
    do_op("w32_add", 64'h89ABCDEF, 64'h76543211, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rx = 64'($urandom);
      ry = 64'($urandom);
      if (i == 3) rx = 64'h7FFFFFFF;
      do_op("rand32", rx, ry, 1'($urandom), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_slice_adder.md
Name: alu_seq_slice_adder

Overview:
- Multi-cycle add/subtract ALU datapath with a handshake.
- Processes a WIDTH-bit operand pair one SLICE-bit digit per clock, least-significant slice first, with a rippling registered carry.
- Generalises the team's fixed 16-bit, 4x4-bit combinational adder: width and slice are parameters, subtract mode is added, and flags are registered.
- Sits between the operand register file and the result/flag writeback stage.

Parameters:
- WIDTH, 16, operand/result width; must be an integer multiple of SLICE.
- SLICE, 4, bits added per clock cycle.
- NSLICE, WIDTH/SLICE, derived localparam: cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only while busy=0
- op  input  1  0 = X+Y, 1 = X-Y; sampled with start
- X  input  WIDTH  operand A; sampled with start
- Y  input  WIDTH  operand B; sampled with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: result and flags just updated
- Z  output  WIDTH  result, held until next completion
- sign  output  1  Z[WIDTH-1]
- zero  output  1  1 when Z == 0
- carry  output  1  carry out of MSB (for subtract: 1 = no borrow)
- overflow  output  1  two's-complement signed overflow
- parity  output  1  even-parity flag: XNOR-reduction of Z (1 when Z has an even number of ones)

Behaviour:
- Reset: asynchronous and active-high; takes effect immediately.
  - Outputs: busy=0, done=0, Z=0, sign=0, zero=0, carry=0, overflow=0, parity=0.
  - State returns to IDLE; slice counter and internal carry are cleared.
- FSM states:
  - IDLE: busy=0. On an edge with start=1:
    - Latch A=X and B = op ? ~Y : Y.
    - Set internal carry cin=op.
    - Clear the slice counter to 0 and go to RUN.
  - RUN: busy=1. Each edge:
    - Compute {c, s} = A[slice] + B[slice] + cin, with SLICE+1-bit arithmetic.
    - Write s into the result shift/assembly register at slice position cnt; cin <= c; cnt++.
    - At the edge that processes slice NSLICE-1, go to DONE.
  - DONE: a single cycle with done=1 and busy=0; returns to IDLE on the next edge.
    - start is accepted in DONE; the next operation begins back-to-back.
- Latency: start sampled at edge k; slices are processed on edges k+1 .. k+NSLICE.
  - Z and flags are updated together on edge k+NSLICE, and done is high for that following cycle.
  - busy is high from edge k until edge k+NSLICE.
  - Throughput: one operation per NSLICE+1 cycles.
- Flag computation happens at the completion edge only. Intermediate slices never appear on Z or the flags.
  - carry = final cin.
  - sign = Zn[WIDTH-1].
  - zero = ~|Zn.
  - parity = ~^Zn.
  - overflow = (A[MSB] & B[MSB] & ~Zn[MSB]) | (~A[MSB] & ~B[MSB] & Zn[MSB]), where B is the effective (possibly inverted) operand.
- start while busy=1 is ignored: no queuing, and operands in flight are unaffected. X, Y and op may change freely after acceptance.
- Wrap-around: the result is modulo 2^WIDTH; the carry-out is reported only through carry.
- Reset mid-operation aborts the operation: no done pulse, and Z and the flags are forced to 0.
- NSLICE=1 (SLICE=WIDTH) is legal: one RUN cycle, then DONE.

Test Plan:
- Reset/idle: assert rst mid-cycle with no clock edge -> all outputs 0 immediately; start held low for 10 cycles -> busy and done remain 0.
- Add overflow (16/4): X=0x7FFF, Y=0x0001, op=0 -> done exactly 5 cycles after the start edge; Z=0x8000, sign=1, overflow=1, carry=0, zero=0, parity=0.
- Add wrap: X=0xFFFF, Y=0x0001, op=0 -> Z=0x0000, carry=1, zero=1, overflow=0, sign=0, parity=1.
- Subtract:
  - X=0x0005, Y=0x0007, op=1 -> Z=0xFFFE, carry=0, sign=1, overflow=0, parity=0.
  - Then X=0x8000, Y=0x0001, op=1 -> Z=0x7FFF, carry=1, overflow=1, sign=0.
- Handshake:
  - Pulse start again during RUN with X=0x1234 -> ignored; the original result is unchanged.
  - start held high through DONE -> second operation accepted back-to-back; done pulses are 5 cycles apart.
  - rst asserted in the 3rd RUN cycle -> no done pulse, and outputs are 0.
- Parametrisation: WIDTH=32, SLICE=8, X=0x89ABCDEF, Y=0x76543211, op=0 -> done after 4 RUN cycles; Z=0x00000000, carry=1, zero=1, overflow=0.
